ifetch_queue: RTL and testbench



---
 rtl/ifetch_queue.sv | 78 +++++++
 tb/tb_ifetch_queue.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch with a prefetch queue feeding decode over valid/ready.
// Define IFQ_BYPASS_EN to forward a return straight to decode when the queue is empty.
module ifetch_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned WIDTH  = 32
) (
    input  logic              clock,
    input  logic              clear,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [WIDTH-1:0]  imem_rdata,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [WIDTH-1:0]  id_instr,
    output logic [31:0]       id_pc
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [31:0]      fetch_pc_q, fetch_pc_d, tag_pc_q, tag_pc_d;
    logic             inflight_q, inflight_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [31:0]      pc_mem [DEPTH];
    logic [WIDTH-1:0] instr_mem [DEPTH];
    logic             ret, bypass, push, pop;

    // Credit uses the registered count, so a pop frees issue space one cycle later.
    assign imem_req  = clear & ~redirect & ((32'(count_q) + 32'(inflight_q)) < DEPTH);
    assign imem_addr = fetch_pc_q[ADDR_W-1:0];
    assign ret       = inflight_q & ~redirect;
`ifdef IFQ_BYPASS_EN
    assign bypass    = ret & (count_q == '0);
`else
    assign bypass    = 1'b0;
`endif
    assign id_valid  = ~redirect & ((count_q != '0) | bypass);
    assign id_instr  = !id_valid ? '0 : bypass ? imem_rdata : instr_mem[rd_ptr_q];
    assign id_pc     = !id_valid ? '0 : bypass ? tag_pc_q : pc_mem[rd_ptr_q];
    assign push      = ret & ~(bypass & id_ready);
    assign pop       = id_valid & id_ready & ~bypass;

    always_comb begin
        fetch_pc_d = redirect ? redirect_pc : fetch_pc_q + 32'(imem_req);
        tag_pc_d   = imem_req ? fetch_pc_q : tag_pc_q;
        inflight_d = imem_req;
        rd_ptr_d   = redirect ? '0 : rd_ptr_q + PW'(pop);
        wr_ptr_d   = redirect ? '0 : wr_ptr_q + PW'(push);
        count_d    = redirect ? '0 : count_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            fetch_pc_q <= '0;
            tag_pc_q   <= '0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            tag_pc_q   <= tag_pc_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (clear && push) begin
            pc_mem[wr_ptr_q]    <= tag_pc_q;
            instr_mem[wr_ptr_q] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: randomized and directed checks of ifetch_queue against a queue-based model.
module tb_ifetch_queue;
`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
    localparam int LAT = 1;
`else
    localparam bit BYP = 1'b0;
    localparam int LAT = 2;
`endif
    localparam int DEPTH = 4;

    logic        clock = 1'b0, clear = 1'b0, redirect = 1'b0, id_ready = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req, id_valid;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata, id_instr, id_pc;
    logic [31:0] mem [256];

    int n_chk = 0, n_fail = 0;
    logic [31:0] m_fpc = '0, m_tag = '0;
    bit          m_infl = 1'b0;
    logic [31:0] mq [$];
    logic        s_req, s_valid, s_fire;
    logic [7:0]  s_addr;
    logic [31:0] s_pc, s_instr;

    ifetch_queue #(.DEPTH(DEPTH), .ADDR_W(8), .WIDTH(32)) dut (
        .clock(clock), .clear(clear), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc)
    );

    always #5 clock = ~clock;
    always @(posedge clock) imem_rdata <= imem_req ? mem[imem_addr] : $urandom;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Compare at the falling edge, then advance the model by one clock.
    task automatic step();
        bit          e_req, ret, byp, e_valid;
        logic [31:0] head;
        @(negedge clock);
        s_req = imem_req; s_addr = imem_addr; s_valid = id_valid;
        s_pc = id_pc; s_instr = id_instr; s_fire = id_valid & id_ready;
        e_req   = clear && !redirect && (mq.size() + int'(m_infl) < DEPTH);
        ret     = m_infl && !redirect;
        byp     = BYP && ret && mq.size() == 0;
        e_valid = !redirect && (mq.size() != 0 || byp);
        head    = byp ? m_tag : (mq.size() != 0 ? mq[0] : 32'h0);
        chk("imem_req", s_req, e_req);
        chk("imem_addr", s_addr, m_fpc[7:0]);
        chk("id_valid", s_valid, e_valid);
        chk("id_pc", s_pc, e_valid ? head : 32'h0);
        chk("id_instr", s_instr, e_valid ? mem[head[7:0]] : 32'h0);
        if (!clear) begin
            m_fpc = '0; m_infl = 0; mq.delete();
        end else if (redirect) begin
            m_fpc = redirect_pc; m_infl = 0; mq.delete();
        end else begin
            if (e_valid && id_ready && !byp) void'(mq.pop_front());
            if (ret && !(byp && id_ready)) mq.push_back(m_tag);
            if (e_req) begin m_tag = m_fpc; m_fpc = m_fpc + 1; end
            m_infl = e_req;
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [31:0] got0, got1;
        int          nd;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h00100093; mem[1] = 32'h00200113; mem[2] = 32'h00209463;
        mem[3] = 32'h00100193; mem[4] = 32'h00100213;
        step(); step();
        chk("rst_req", s_req, 0); chk("rst_addr", s_addr, 0); chk("rst_valid", s_valid, 0);
        chk("rst_pc", s_pc, 0); chk("rst_instr", s_instr, 0);

        // Free run from reset
        clear = 1; id_ready = 1;
        for (int c = 0; c < 8; c++) begin
            step();
            if (c == 0) chk("first_addr", s_addr, 0);
            if (c == LAT - 1) chk("pre_valid", s_valid, 0);
            if (c >= LAT && c <= LAT + 4) chk("run_pc", s_pc, c - LAT);
            if (c == LAT) chk("run_instr0", s_instr, 32'h00100093);
            if (c == LAT + 4) chk("run_instr4", s_instr, 32'h00100213);
        end

        // Stall until full, then drain
        clear = 0; step(); clear = 1; id_ready = 0;
        repeat (10) step();
        chk("full_req", s_req, 0); chk("full_valid", s_valid, 1); chk("full_pc", s_pc, 0);
        id_ready = 1;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("drain_valid", s_valid, 1);
            chk("drain_pc", s_pc, c);
        end

        // Redirect with a full-ish queue and a request in flight
        clear = 0; step(); clear = 1; id_ready = 0;
        repeat (3) step();
        redirect = 1; redirect_pc = 5; id_ready = 1;
        step();
        chk("redir_valid", s_valid, 0); chk("redir_req", s_req, 0);
        redirect = 0;
        step();
        chk("redir_next_req", s_req, 1); chk("redir_next_addr", s_addr, 5);
        got0 = 32'hFFFF_FFFF;
        for (int c = 0; c < 6; c++) begin
            step();
            if (s_fire && got0 == 32'hFFFF_FFFF) got0 = s_pc;
        end
        chk("redir_first_pc", got0, 5);

        // Redirect during streaming (pop + return same cycle) into the address wrap
        redirect = 1; redirect_pc = 32'hFF;
        step();
        chk("wrap_redir_req", s_req, 0); chk("wrap_redir_valid", s_valid, 0);
        redirect = 0;
        step(); chk("wrap_addr0", s_addr, 8'hFF);
        step(); chk("wrap_addr1", s_addr, 8'h00);
        nd = 0; got0 = '0; got1 = '0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (s_fire && nd == 0) got0 = s_pc;
            if (s_fire && nd == 1) got1 = s_pc;
            if (s_fire) nd++;
        end
        chk("wrap_pc0", got0, 32'hFF); chk("wrap_pc1", got1, 32'h100);

        // Reset overrides redirect
        clear = 0; redirect = 1; redirect_pc = 32'h40;
        step();
        redirect = 0;
        step();
        chk("clr_valid", s_valid, 0); chk("clr_pc", s_pc, 0); chk("clr_instr", s_instr, 0);
        chk("clr_req", s_req, 0); chk("clr_addr", s_addr, 0);
        clear = 1;
        step();
        chk("clr_restart_req", s_req, 1); chk("clr_restart_addr", s_addr, 0);

        repeat (3000) begin
            clear       = $urandom_range(99) != 0;
            redirect    = $urandom_range(19) == 0;
            redirect_pc = $urandom_range(1) ? $urandom : 32'hF8 + 32'($urandom_range(15));
            id_ready    = $urandom_range(9) < 6;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
